cache_axi_bridge: RTL and testbench
===================================

Name: cache_axi_bridge

Overview:
- Parametrised successor to the single-outstanding cache-to-AXI bridge; sits between the I-cache/D-cache miss/writeback ports and the AXI3 master port.
- Round-robin arbitration between the two read clients.
- WBUF_DEPTH-entry D-cache write buffer that drains in FIFO order, with read-after-write hazard blocking against every occupied entry.
- Line length is set by LINE_WORDS.

Parameters:
- LINE_WORDS, 4: 32-bit words per cache line; power of 2, 2..16. Line bursts use arlen/awlen = LINE_WORDS-1.
- WBUF_DEPTH, 2: write-buffer entries, 1..8.
- OFF_W, $clog2(LINE_WORDS*4): line-offset bits (derived, not overridable).

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- ic_rd_req, dc_rd_req  in  1  read request
- ic_rd_type, dc_rd_type  in  3  000 byte, 001 half, 010 word, 100 line
- ic_rd_addr, dc_rd_addr  in  32  read address
- ic_rd_rdy, dc_rd_rdy  out  1  request accepted when req&rdy
- ic_ret_valid, dc_ret_valid  out  1  return beat valid
- ic_ret_last, dc_ret_last  out  1  final beat
- ic_ret_data, dc_ret_data  out  32  return data
- dc_wr_req  in  1  write request
- dc_wr_type  in  3  encoding as rd_type
- dc_wr_addr  in  32  write address
- dc_wr_wstrb  in  4  byte strobe (ignored for line writes)
- dc_wr_data  in  32*LINE_WORDS  write data; word0 = bits[31:0]
- dc_wr_rdy  out  1  write accepted when req&rdy
- AXI3 AR/R/AW/W/B  standard directions  ids 4, addr 32, len 8, size 3, burst 2, lock 2, cache 4, prot 3, data 32, strb 4, resp 2

Behaviour:
- Reset: all valid/rdy-internal state cleared; arvalid, rready, awvalid, wvalid, bready, all ret_valid = 0; buffer empty; RR pointer selects dcache first.
- AXI constants:
  - burst = INCR, lock/cache/prot = 0.
  - arid = 0 for icache, 1 for dcache; awid = wid = 1.
  - size = 0/1/2 per type (line → 2).
  - len = LINE_WORDS-1 for line, else 0.
- Read FSM states: R_IDLE, R_AR, R_DATA.
  - In R_IDLE, a request is eligible if req=1 and no hazard.
  - With both eligible, grant goes to the client not granted last; the RR pointer updates on each grant.
  - rd_rdy is high only for the granted client in R_IDLE (combinational).
  - Acceptance latches id/addr/type and moves to R_AR.
  - arvalid is high in R_AR; on arready move to R_DATA.
  - rready = 1 in R_DATA. A beat is valid when rvalid & rready, steered by rid[0]. ret_last = rlast.
  - The beat carrying rlast returns the FSM to R_IDLE. The next grant is possible the following cycle; the accepted request's arvalid rises one cycle after acceptance.
  - Exactly one read outstanding at a time.
- Hazard: a read is blocked while rd_addr[31:OFF_W] equals the line address of any valid buffer entry, including the entry currently draining. The block lasts until that entry's B response retires it.
- Write buffer: circular FIFO with head/tail pointers and a count of 0..WBUF_DEPTH.
  - dc_wr_rdy = (count != WBUF_DEPTH). Acceptance enqueues addr/type/wstrb/data.
  - Line entries force strobe 4'hF.
  - Acceptance and B-retire in the same cycle leave count unchanged.
  - An enqueue when full is impossible because rdy=0.
- Write drain FSM states: W_IDLE, W_ADDR_DATA, W_RESP.
  - W_IDLE with count>0: awvalid and wvalid rise together from the head entry.
  - The AW handshake and W beats complete independently; W beats do not wait for awready.
  - Beat k (0..LINE_WORDS-1) carries word k; a beat counter advances on wvalid&wready.
  - wlast = 1 on the final beat (beat 0 for non-line writes).
  - After both AW is done and the wlast beat is sent, enter W_RESP with bready = 1.
  - On bvalid, pop the head (count-1) and return to W_IDLE. bresp is ignored.
- Reads and writes proceed concurrently. No read/write ordering is enforced other than the hazard check.
- Reset mid-burst: all state is cleared and any partial transaction is abandoned; the interconnect is reset with the core.

Test Plan:
- Both rd_req high, line type, icache addr 0x1000, dcache addr 0x2000: dcache granted first (arid=1, arlen=3, araddr=0x2000), then icache (arid=0). The 4 beats on each port have ret_last only on the 4th.
- dcache requests continuously while icache is held: the grants alternate, so icache waits at most one transaction.
- Line write to 0x80 with data words 0x11,0x22,0x33,0x44 and awready delayed 3 cycles: W beats go out in order 0x11..0x44, wstrb=F, wlast on 0x44, pop only after bvalid.
- Fill buffer with WBUF_DEPTH writes while bvalid is held low: dc_wr_rdy=0 when full. It rises the cycle after the first B. Drain order is FIFO.
- dc_rd_addr 0x84 while a write to line 0x80 is buffered: dc_rd_rdy stays 0 until B retires that entry. An icache read to 0x100 still proceeds meanwhile.
- Byte read, type 000 at 0x3: arsize=0, arlen=0, single beat with ret_last=1. Assert aresetn=0 mid-line-read: all valids drop to 0 next cycle.

Source files
------------

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: round-robin I/D-cache read arbiter plus FIFO D-cache write buffer onto one AXI3 master port.
// Reads are blocked while their line sits in the write buffer, so a read never overtakes a buffered write.
module cache_axi_bridge #(
    parameter int LINE_WORDS = 4,
    parameter int WBUF_DEPTH = 2,
    localparam int OFF_W = $clog2(LINE_WORDS * 4)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      ic_rd_req,
    input  logic [2:0]                ic_rd_type,
    input  logic [31:0]               ic_rd_addr,
    output logic                      ic_rd_rdy,
    output logic                      ic_ret_valid,
    output logic                      ic_ret_last,
    output logic [31:0]               ic_ret_data,
    input  logic                      dc_rd_req,
    input  logic [2:0]                dc_rd_type,
    input  logic [31:0]               dc_rd_addr,
    output logic                      dc_rd_rdy,
    output logic                      dc_ret_valid,
    output logic                      dc_ret_last,
    output logic [31:0]               dc_ret_data,
    input  logic                      dc_wr_req,
    input  logic [2:0]                dc_wr_type,
    input  logic [31:0]               dc_wr_addr,
    input  logic [3:0]                dc_wr_wstrb,
    input  logic [32*LINE_WORDS-1:0]  dc_wr_data,
    output logic                      dc_wr_rdy,
    output logic [3:0]                arid,
    output logic [31:0]               araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic [1:0]                arlock,
    output logic [3:0]                arcache,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [3:0]                rid,
    input  logic [31:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    output logic [3:0]                awid,
    output logic [31:0]               awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic [1:0]                awlock,
    output logic [3:0]                awcache,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [3:0]                wid,
    output logic [31:0]               wdata,
    output logic [3:0]                wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [3:0]                bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);
    localparam int PW = WBUF_DEPTH > 1 ? $clog2(WBUF_DEPTH) : 1;
    localparam int CW = $clog2(WBUF_DEPTH + 1);
    localparam int BW = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} w_state_t;

    r_state_t r_state;
    w_state_t w_state;
    logic        prio_dc, r_dc;
    logic [31:0] r_addr;
    logic [2:0]  r_type;
    logic        hz_ic, hz_dc, gnt_ic, gnt_dc, r_idle;

    logic [31:0]                 wb_addr [WBUF_DEPTH];
    logic [2:0]                  wb_type [WBUF_DEPTH];
    logic [3:0]                  wb_strb [WBUF_DEPTH];
    logic [LINE_WORDS-1:0][31:0] wb_data [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0]       wb_vld;
    logic [PW-1:0]               wb_head, wb_tail;
    logic [CW-1:0]               wb_cnt;
    logic [BW-1:0]               w_beat;
    logic aw_done, w_done, w_push, w_pop, aw_hs, w_hs, h_line, unused;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(WBUF_DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // Every occupied entry, including the one being drained, blocks reads to its line.
    always_comb begin
        hz_ic = 1'b0;
        hz_dc = 1'b0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            hz_ic = hz_ic | (wb_vld[i] & (wb_addr[i][31:OFF_W] == ic_rd_addr[31:OFF_W]));
            hz_dc = hz_dc | (wb_vld[i] & (wb_addr[i][31:OFF_W] == dc_rd_addr[31:OFF_W]));
        end
    end

    assign r_idle    = r_state == R_IDLE;
    assign gnt_dc    = r_idle & dc_rd_req & ~hz_dc & (prio_dc | ~ic_rd_req | hz_ic);
    assign gnt_ic    = r_idle & ic_rd_req & ~hz_ic & ~gnt_dc;
    assign ic_rd_rdy = gnt_ic;
    assign dc_rd_rdy = gnt_dc;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            prio_dc <= 1'b1;
            r_dc    <= 1'b0;
            r_addr  <= '0;
            r_type  <= '0;
        end else if (gnt_ic || gnt_dc) begin
            r_state <= R_AR;
            r_dc    <= gnt_dc;
            r_addr  <= gnt_dc ? dc_rd_addr : ic_rd_addr;
            r_type  <= gnt_dc ? dc_rd_type : ic_rd_type;
            prio_dc <= gnt_ic;
        end else if (r_state == R_AR && arready) begin
            r_state <= R_DATA;
        end else if (r_state == R_DATA && rvalid && rlast) begin
            r_state <= R_IDLE;
        end
    end

    assign arid    = {3'b000, r_dc};
    assign araddr  = r_addr;
    assign arlen   = r_type[2] ? 8'(LINE_WORDS - 1) : 8'd0;
    assign arsize  = r_type[2] ? 3'd2 : {1'b0, r_type[1:0]};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'h0;
    assign arprot  = 3'h0;
    assign arvalid = r_state == R_AR;
    assign rready  = r_state == R_DATA;

    assign ic_ret_valid = rvalid & rready & ~rid[0];
    assign dc_ret_valid = rvalid & rready & rid[0];
    assign ic_ret_last  = rlast & ic_ret_valid;
    assign dc_ret_last  = rlast & dc_ret_valid;
    assign ic_ret_data  = rdata;
    assign dc_ret_data  = rdata;

    assign dc_wr_rdy = wb_cnt != CW'(WBUF_DEPTH);
    assign w_push    = dc_wr_req & dc_wr_rdy;
    assign w_pop     = (w_state == W_RESP) & bvalid;
    assign h_line    = wb_type[wb_head][2];

    always_ff @(posedge aclk) begin
        if (w_push) begin
            wb_addr[wb_tail] <= dc_wr_addr;
            wb_type[wb_tail] <= dc_wr_type;
            wb_strb[wb_tail] <= dc_wr_type[2] ? 4'hF : dc_wr_wstrb;
            wb_data[wb_tail] <= dc_wr_data;
        end
    end

    assign awid    = 4'd1;
    assign awaddr  = wb_addr[wb_head];
    assign awlen   = h_line ? 8'(LINE_WORDS - 1) : 8'd0;
    assign awsize  = h_line ? 3'd2 : {1'b0, wb_type[wb_head][1:0]};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'h0;
    assign awprot  = 3'h0;
    assign awvalid = (w_state == W_ADDR_DATA) & ~aw_done;
    assign wid     = 4'd1;
    assign wdata   = wb_data[wb_head][w_beat];
    assign wstrb   = wb_strb[wb_head];
    assign wlast   = w_beat == (h_line ? BW'(LINE_WORDS - 1) : BW'(0));
    assign wvalid  = (w_state == W_ADDR_DATA) & ~w_done;
    assign bready  = w_state == W_RESP;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign unused  = ^{rresp, rid[3:1], bid, bresp};

    // AW and W run independently; the response phase waits for both to finish.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            wb_head <= '0;
            wb_tail <= '0;
            wb_cnt  <= '0;
            wb_vld  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_beat  <= '0;
        end else begin
            if (w_push) wb_tail <= nxt(wb_tail);
            if (w_push) wb_vld[wb_tail] <= 1'b1;
            if (w_pop) wb_head <= nxt(wb_head);
            if (w_pop) wb_vld[wb_head] <= 1'b0;
            wb_cnt <= wb_cnt + CW'(w_push) - CW'(w_pop);
            if (w_state == W_IDLE && wb_cnt != '0) begin
                w_state <= W_ADDR_DATA;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                w_beat  <= '0;
            end else if (w_state == W_ADDR_DATA) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs && !wlast) w_beat <= w_beat + BW'(1);
                if (w_hs && wlast) w_done <= 1'b1;
                if ((aw_done || aw_hs) && (w_done || (w_hs && wlast))) w_state <= W_RESP;
            end else if (w_pop) begin
                w_state <= W_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge: scoreboard bench with a small AXI3 slave; expected AR/R/AW/W traffic is queued at request acceptance.
module tb_cache_axi_bridge;
    logic aclk, aresetn;
    logic ic_rd_req, dc_rd_req, ic_rd_rdy, dc_rd_rdy;
    logic [2:0] ic_rd_type, dc_rd_type;
    logic [31:0] ic_rd_addr, dc_rd_addr;
    logic ic_ret_valid, dc_ret_valid, ic_ret_last, dc_ret_last;
    logic [31:0] ic_ret_data, dc_ret_data;
    logic dc_wr_req, dc_wr_rdy;
    logic [2:0] dc_wr_type;
    logic [31:0] dc_wr_addr;
    logic [3:0] dc_wr_wstrb;
    logic [127:0] dc_wr_data;
    logic [3:0] arid, arcache, rid, awid, awcache, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, arprot, awsize, awprot;
    logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
    logic arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int total, bad;
    int ic_acc, dc_acc, wr_acc, b_cnt, b_at_dcacc, w_tot, w_at_aw, ic_rets, dc_rets;
    bit glog[$];
    logic [32:0] ic_q[$], dc_q[$];
    logic [57:0] ar_q[$], aw_q[$];
    logic [40:0] w_q[$];
    bit r_act, r_id, b_hold;
    logic [31:0] r_addr;
    int r_beat, r_len, aw_cnt, aw_delay, b_pending;

    cache_axi_bridge dut (
        .aclk(aclk), .aresetn(aresetn),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
        .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
        .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
        .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr), .dc_wr_wstrb(dc_wr_wstrb),
        .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] md(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
    endfunction

    function automatic logic [57:0] axe(input logic [3:0] id, input logic [31:0] a, input logic [2:0] t);
        return {id, a, t[2] ? 8'd3 : 8'd0, t[2] ? 3'd2 : {1'b0, t[1:0]}, 2'b01, 2'b00, 4'h0, 3'h0};
    endfunction

    task automatic push_rd(input bit dc, input logic [2:0] t, input logic [31:0] a);
        int n = t[2] ? 4 : 1;
        ar_q.push_back(axe({3'b000, dc}, a, t));
        for (int k = 0; k < n; k++)
            if (dc) dc_q.push_back({k == n - 1, md(a + 32'(4 * k))});
            else ic_q.push_back({k == n - 1, md(a + 32'(4 * k))});
    endtask

    task automatic push_wr(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s, input logic [127:0] d);
        int n = t[2] ? 4 : 1;
        aw_q.push_back(axe(4'd1, a, t));
        for (int k = 0; k < n; k++) w_q.push_back({4'd1, d[32 * k +: 32], t[2] ? 4'hF : s, k == n - 1});
    endtask

    // Slave outputs are driven on the falling edge; handshakes due at the next rising edge are scored 1 ns later.
    always @(negedge aclk) begin
        arready = !r_act;
        rvalid  = r_act;
        rid     = {3'b000, r_id};
        rdata   = md(r_addr + 32'(4 * r_beat));
        rlast   = r_act && r_beat == r_len;
        rresp   = 2'b00;
        awready = awvalid && aw_cnt >= aw_delay;
        wready  = 1'b1;
        bvalid  = b_pending > 0 && !b_hold;
        bid     = 4'd1;
        bresp   = 2'b00;
        #1;
        if (!aresetn) begin
            ic_q.delete(); dc_q.delete(); ar_q.delete(); aw_q.delete(); w_q.delete();
            r_act = 0; aw_cnt = 0; b_pending = 0;
        end else begin
            if (ic_rd_req && ic_rd_rdy) begin push_rd(0, ic_rd_type, ic_rd_addr); glog.push_back(0); ic_acc++; end
            if (dc_rd_req && dc_rd_rdy) begin push_rd(1, dc_rd_type, dc_rd_addr); glog.push_back(1); dc_acc++; b_at_dcacc = b_cnt; end
            if (dc_wr_req && dc_wr_rdy) begin push_wr(dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data); wr_acc++; end
            if (rvalid && rready) begin
                if (r_beat == r_len) r_act = 0;
                r_beat++;
            end
            if (arvalid && arready) begin
                chk("ar_expected", ar_q.size() != 0, 1);
                if (ar_q.size() != 0)
                    chk("ar", {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot}, ar_q.pop_front());
                r_act = 1; r_id = arid[0]; r_addr = araddr; r_len = int'(arlen); r_beat = 0;
            end
            if (ic_ret_valid) begin
                ic_rets++;
                chk("ic_ret_expected", ic_q.size() != 0, 1);
                if (ic_q.size() != 0) chk("ic_ret", {ic_ret_last, ic_ret_data}, ic_q.pop_front());
            end
            if (dc_ret_valid) begin
                dc_rets++;
                chk("dc_ret_expected", dc_q.size() != 0, 1);
                if (dc_q.size() != 0) chk("dc_ret", {dc_ret_last, dc_ret_data}, dc_q.pop_front());
            end
            if (awvalid && awready) begin
                w_at_aw = w_tot;
                aw_cnt = 0;
                chk("aw_expected", aw_q.size() != 0, 1);
                if (aw_q.size() != 0)
                    chk("aw", {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot}, aw_q.pop_front());
            end else if (awvalid) aw_cnt++;
            if (wvalid && wready) begin
                w_tot++;
                chk("w_expected", w_q.size() != 0, 1);
                if (w_q.size() != 0) chk("w", {wid, wdata, wstrb, wlast}, w_q.pop_front());
                if (wlast) b_pending++;
            end
            if (bvalid && bready) begin b_pending--; b_cnt++; end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic rd(input bit ie, input logic [2:0] it, input logic [31:0] ia,
                      input bit de, input logic [2:0] dt, input logic [31:0] da);
        int ic0 = ic_acc;
        int dc0 = dc_acc;
        ic_rd_req = ie; ic_rd_type = it; ic_rd_addr = ia;
        dc_rd_req = de; dc_rd_type = dt; dc_rd_addr = da;
        for (int i = 0; i < 400 && (ic_rd_req || dc_rd_req); i++) begin
            @(negedge aclk);
            if (ic_acc != ic0) ic_rd_req = 0;
            if (dc_acc != dc0) dc_rd_req = 0;
        end
        chk("rd_accept_timeout", {ic_rd_req, dc_rd_req}, 0);
        ic_rd_req = 0; dc_rd_req = 0;
    endtask

    task automatic wr(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s, input logic [127:0] d);
        int w0 = wr_acc;
        dc_wr_req = 1; dc_wr_type = t; dc_wr_addr = a; dc_wr_wstrb = s; dc_wr_data = d;
        for (int i = 0; i < 400 && dc_wr_req; i++) begin
            @(negedge aclk);
            if (wr_acc != w0) dc_wr_req = 0;
        end
        chk("wr_accept_timeout", dc_wr_req, 0);
        dc_wr_req = 0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 1000; i++) begin
            @(negedge aclk);
            if (ic_q.size() == 0 && dc_q.size() == 0 && ar_q.size() == 0 && aw_q.size() == 0 && w_q.size() == 0
                && b_pending == 0 && !arvalid && !rready && !awvalid && !wvalid && !bready) break;
        end
        chk("drain_timeout", i < 1000, 1);
    endtask

    initial begin
        int base, w0, ic0, dc0, b0, r0;
        bit low_ok;
        total = 0; bad = 0; aresetn = 0; b_hold = 0; aw_delay = 0;
        ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0; dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
        dc_wr_req = 0; dc_wr_type = 0; dc_wr_addr = 0; dc_wr_wstrb = 0; dc_wr_data = 0;
        tick(3);
        chk("reset_outs", {arvalid, rready, awvalid, wvalid, bready, ic_ret_valid, dc_ret_valid,
                           ic_rd_rdy, dc_rd_rdy, dc_wr_rdy}, 10'b0000000001);
        aresetn = 1;
        tick(1);

        rd(1, 3'b100, 32'h1000, 1, 3'b100, 32'h2000);
        drain();
        chk("s1_order", {glog[0], glog[1]}, 2'b10);
        chk("s1_ic_beats", ic_rets, 4);
        chk("s1_dc_beats", dc_rets, 4);

        base = glog.size();
        ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1000;
        dc_rd_req = 1; dc_rd_type = 3'b100; dc_rd_addr = 32'h2000;
        for (int i = 0; i < 2000; i++) begin
            @(negedge aclk);
            if (glog.size() >= base + 6) break;
        end
        ic_rd_req = 0; dc_rd_req = 0;
        drain();
        chk("s2_grants", glog.size() - base, 6);
        for (int k = 0; k < 6; k++) chk("s2_alternate", glog[base + k], k % 2 == 0);

        b_hold = 1; aw_delay = 3; w0 = w_tot;
        wr(3'b100, 32'h80, 4'h0, {32'h44, 32'h33, 32'h22, 32'h11});
        for (int i = 0; i < 100 && (b_pending == 0 || aw_q.size() != 0); i++) @(negedge aclk);
        chk("s3_wlast_sent", b_pending, 1);
        chk("s3_w_before_aw", w_at_aw - w0 >= 3, 1);
        ic0 = ic_acc; dc0 = dc_acc;
        dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h84;
        ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h100;
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk);
            if (ic_acc != ic0) ic_rd_req = 0;
        end
        chk("haz_dc_blocked", dc_acc - dc0, 0);
        chk("haz_ic_proceeds", ic_acc - ic0, 1);
        b0 = b_cnt; b_hold = 0;
        for (int i = 0; i < 100 && dc_rd_req; i++) begin
            @(negedge aclk);
            if (dc_acc != dc0) dc_rd_req = 0;
        end
        chk("haz_dc_released", dc_rd_req, 0);
        chk("haz_after_b", b_at_dcacc - b0, 1);
        dc_rd_req = 0; ic_rd_req = 0; aw_delay = 0;
        drain();

        b_hold = 1;
        wr(3'b010, 32'h200, 4'h3, {96'h0, 32'h0000_AAAA});
        wr(3'b010, 32'h300, 4'hC, {96'h0, 32'h0000_BBBB});
        tick(4);
        chk("s4_full_rdy", dc_wr_rdy, 0);
        b0 = b_cnt; low_ok = 1; b_hold = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (b_cnt != b0) break;
            if (dc_wr_rdy) low_ok = 0;
        end
        chk("s4_rdy_after_b", dc_wr_rdy, 1);
        chk("s4_rdy_low_while_full", low_ok, 1);
        drain();

        dc0 = dc_rets;
        rd(0, 3'b000, 32'h0, 1, 3'b000, 32'h3);
        drain();
        chk("s5_byte_beats", dc_rets - dc0, 1);

        r0 = ic_rets;
        rd(1, 3'b100, 32'h4000, 0, 3'b000, 32'h0);
        for (int i = 0; i < 50 && ic_rets == r0; i++) @(negedge aclk);
        chk("s6_mid_burst", {rready, ic_rets > r0}, 2'b11);
        aresetn = 0;
        @(negedge aclk);
        chk("s6_reset_outs", {arvalid, rready, awvalid, wvalid, bready, ic_ret_valid, dc_ret_valid}, 0);
        aresetn = 1;
        tick(1);
        dc0 = dc_rets;
        rd(0, 3'b000, 32'h0, 1, 3'b010, 32'h500);
        drain();
        chk("s6_recover_beats", dc_rets - dc0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
